// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multi-cycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, driving mux selects, ALU op and write enables.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUControl,
  output logic               shift_right_type,
  output logic               instr_done,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRA    = 4'd11,
    S_JALRB    = 4'd12,
    S_LUI      = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SR   = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  state_t     r_state;
  state_t     w_next;
  logic       r_fault;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_bit30;
  logic       w_unused;
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_done;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_bit30  = instr[30];
  assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

  // funct3 -> ALU op; SUB only when the caller says bit 30 selects it (R-type)
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
        else           w_next = S_FETCH;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALRA;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (w_opcode == OP_LOAD) w_next = S_MEMREAD;
        else                     w_next = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) w_next = S_MEMWB;
        else           w_next = S_MEMREAD;
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) w_next = S_FETCH;
        else           w_next = S_MEMWRITE;
      end
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH: begin
        if (w_funct3[2:1] == 2'b00) w_next = S_FETCH;
        else                        w_next = S_FAULT;
      end
      S_JAL:      w_next = S_ALUWB;
      S_JALRA:    w_next = S_JALRB;
      S_JALRB:    w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FAULT;
    endcase
  end

  // State register and sticky fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= r_fault | (w_next == S_FAULT);
    end
  end

  // Per-state control; enables depend on mem_ready/zero within the same cycle
  always_comb begin
    w_pc_write       = 1'b0;
    AdrSrc           = 1'b0;
    w_ir_write       = 1'b0;
    w_mem_write      = 1'b0;
    w_reg_write      = 1'b0;
    ResultSrc        = 2'b00;
    ALUSrcA          = 2'b00;
    ALUSrcB          = 2'b00;
    ALUControl       = ALU_ADD;
    shift_right_type = 1'b0;
    w_done           = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_pc_write = mem_ready;
        w_ir_write = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        w_done      = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA          = 2'b10;
        ALUSrcB          = 2'b00;
        ALUControl       = alu_decode(w_funct3, w_bit30);
        shift_right_type = (w_funct3 == 3'b101) & w_bit30;
      end
      S_EXECI: begin
        ALUSrcA          = 2'b10;
        ALUSrcB          = 2'b01;
        ALUControl       = alu_decode(w_funct3, 1'b0);
        shift_right_type = (w_funct3 == 3'b101) & w_bit30;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        // only beq/bne are legal here; anything else heads to FAULT without a PC update
        if (w_funct3[2:1] == 2'b00) begin
          w_pc_write = zero ^ w_funct3[0];
          w_done     = 1'b1;
        end else begin
          w_pc_write = 1'b0;
          w_done     = 1'b0;
        end
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
      end
      S_JALRA: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JALRB: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_FAULT: w_done = 1'b0;
      default: w_done = 1'b0;
    endcase
  end

  // Reset kills every write in the same cycle so an aborted instruction leaves no trace
  assign PCWrite    = w_pc_write  & ~rst;
  assign IRWrite    = w_ir_write  & ~rst;
  assign MemWrite   = w_mem_write & ~rst;
  assign RegWrite   = w_reg_write & ~rst;
  assign instr_done = w_done      & ~rst;
  assign fault      = r_fault;
  assign state_o    = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors are queued
// when stimulus is driven and checked against the DUT on the falling edge.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUControl;
  logic        shift_right_type, instr_done, fault;
  logic [3:0]  state_o;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .shift_right_type(shift_right_type),
    .instr_done(instr_done), .fault(fault), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;
  localparam logic [3:0] A_SLT = 4'b0101;
  localparam logic [3:0] A_SR  = 4'b0111;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_SRAI = 32'h4030D293;
  localparam logic [31:0] I_ADDI = 32'h40008293;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic [21:0] sb_q[$];
  logic [21:0] mask_q[$];
  string       tag_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [21:0] ex(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic irw, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [3:0] alu,
                                     input logic srt, input logic done, input logic flt);
    return {st, pcw, adr, irw, mw, rw, rs, a, b, alu, srt, done, flt};
  endfunction

  function automatic logic [21:0] f_fetch(input logic rdy);
    return ex(4'd0, rdy, 1'b0, rdy, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, A_ADD, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [21:0] f_dec();
    return ex(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [21:0] f_wb();
    return ex(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [21:0] f_flt();
    return ex(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b0, 1'b1);
  endfunction

  // one clock cycle: drive inputs, queue the expectation, compare on the falling edge
  task automatic cycm(input string tag, input logic [31:0] ins, input logic z, input logic rdy,
                      input logic r, input logic [21:0] e, input logic [21:0] m);
    logic [21:0] obs, exp_v, msk;
    string       t;
    @(posedge clk);
    #1;
    instr = ins; zero = z; mem_ready = rdy; rst = r;
    sb_q.push_back(e); mask_q.push_back(m); tag_q.push_back(tag);
    @(negedge clk);
    exp_v = sb_q.pop_front();
    msk   = mask_q.pop_front();
    t     = tag_q.pop_front();
    obs = {state_o, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, shift_right_type, instr_done, fault};
    n_assert++;
    assert ((obs & msk) === (exp_v & msk)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (mask %h)", t, obs, exp_v, msk);
    end
  endtask

  task automatic cyc(input string tag, input logic [31:0] ins, input logic z, input logic rdy,
                     input logic r, input logic [21:0] e);
    cycm(tag, ins, z, rdy, r, e, 22'h3FFFFF);
  endtask

  task automatic fd(input string tag, input logic [31:0] ins);
    cyc({tag, "_fetch"}, ins, 1'b0, 1'b1, 1'b0, f_fetch(1'b1));
    cyc({tag, "_decode"}, ins, 1'b0, 1'b1, 1'b0, f_dec());
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;

    // reset: FETCH with all enables suppressed
    cyc("reset", 32'h0, 1'b0, 1'b1, 1'b1,
        ex(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, A_ADD, 1'b0, 1'b0, 1'b0));

    // R-type
    fd("add", I_ADD);
    cyc("add_execr", I_ADD, 1'b0, 1'b1, 1'b0,
        ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("add_wb", I_ADD, 1'b0, 1'b1, 1'b0, f_wb());
    fd("sub", I_SUB);
    cyc("sub_execr", I_SUB, 1'b0, 1'b1, 1'b0,
        ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SUB, 1'b0, 1'b0, 1'b0));
    cyc("sub_wb", I_SUB, 1'b0, 1'b1, 1'b0, f_wb());
    fd("sra", I_SRA);
    cyc("sra_execr", I_SRA, 1'b0, 1'b1, 1'b0,
        ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SR, 1'b1, 1'b0, 1'b0));
    cyc("sra_wb", I_SRA, 1'b0, 1'b1, 1'b0, f_wb());
    fd("slt", I_SLT);
    cyc("slt_execr", I_SLT, 1'b0, 1'b1, 1'b0,
        ex(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SLT, 1'b0, 1'b0, 1'b0));
    cyc("slt_wb", I_SLT, 1'b0, 1'b1, 1'b0, f_wb());

    // load with two wait cycles in FETCH and in MEMREAD: 9 cycles
    cyc("lw_fetch_w1", I_LW, 1'b0, 1'b0, 1'b0, f_fetch(1'b0));
    cyc("lw_fetch_w2", I_LW, 1'b0, 1'b0, 1'b0, f_fetch(1'b0));
    cyc("lw_fetch_rdy", I_LW, 1'b0, 1'b1, 1'b0, f_fetch(1'b1));
    cyc("lw_decode", I_LW, 1'b0, 1'b1, 1'b0, f_dec());
    cyc("lw_memadr", I_LW, 1'b0, 1'b1, 1'b0,
        ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("lw_memread", I_LW, 1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0,
          ex(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("lw_memwb", I_LW, 1'b0, 1'b1, 1'b0,
        ex(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, A_ADD, 1'b0, 1'b1, 1'b0));

    // store with one wait cycle; instr_done only on the ready cycle
    fd("sw", I_SW);
    cyc("sw_memadr", I_SW, 1'b0, 1'b1, 1'b0,
        ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("sw_memwrite_wait", I_SW, 1'b0, 1'b0, 1'b0,
        ex(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("sw_memwrite_rdy", I_SW, 1'b0, 1'b1, 1'b0,
        ex(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b1, 1'b0));

    // branches: beq takes on zero, bne on !zero
    for (int k = 0; k < 4; k++) begin
      logic [31:0] bi;
      logic        z, take;
      bi   = (k < 2) ? I_BEQ : I_BNE;
      z    = k[0];
      take = (k < 2) ? z : ~z;
      fd("branch", bi);
      cyc("branch_exec", bi, z, 1'b1, 1'b0,
          ex(4'd9, take, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SUB, 1'b0, 1'b1, 1'b0));
    end

    // jal, jalr, lui
    fd("jal", I_JAL);
    cyc("jal_exec", I_JAL, 1'b0, 1'b1, 1'b0,
        ex(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("jal_wb", I_JAL, 1'b0, 1'b1, 1'b0, f_wb());
    fd("jalr", I_JALR);
    cyc("jalr_a", I_JALR, 1'b0, 1'b1, 1'b0,
        ex(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("jalr_b", I_JALR, 1'b0, 1'b1, 1'b0,
        ex(4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("jalr_wb", I_JALR, 1'b0, 1'b1, 1'b0, f_wb());
    fd("lui", I_LUI);
    cyc("lui_exec", I_LUI, 1'b0, 1'b1, 1'b0,
        ex(4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("lui_wb", I_LUI, 1'b0, 1'b1, 1'b0, f_wb());

    // I-type: srai sets arithmetic shift; addi with bit 30 set stays ADD
    fd("srai", I_SRAI);
    cyc("srai_execi", I_SRAI, 1'b0, 1'b1, 1'b0,
        ex(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_SR, 1'b1, 1'b0, 1'b0));
    cyc("srai_wb", I_SRAI, 1'b0, 1'b1, 1'b0, f_wb());
    fd("addi", I_ADDI);
    cyc("addi_execi", I_ADDI, 1'b0, 1'b1, 1'b0,
        ex(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("addi_wb", I_ADDI, 1'b0, 1'b1, 1'b0, f_wb());

    // blt is not supported: BRANCH without PC write or done, then FAULT
    fd("blt", I_BLT);
    cyc("blt_exec", I_BLT, 1'b1, 1'b1, 1'b0,
        ex(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, A_SUB, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("blt_fault", I_BLT, 1'b1, 1'b1, 1'b0, f_flt());
    cycm("blt_fault_rst", I_BLT, 1'b0, 1'b1, 1'b1, f_flt(), 22'h3FFFFE);

    // illegal opcode: FAULT held for 20 cycles regardless of inputs, cleared by reset
    fd("ill", I_ILL);
    for (int i = 0; i < 20; i++)
      cyc("ill_fault", I_ILL, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, f_flt());
    cycm("ill_fault_rst", I_ILL, 1'b0, 1'b1, 1'b1, f_flt(), 22'h3FFFFE);
    cyc("ill_after_rst", I_ADD, 1'b0, 1'b0, 1'b0, f_fetch(1'b0));

    // reset during a stalled store: MemWrite drops in the same cycle, back to FETCH
    cyc("swr_fetch", I_SW, 1'b0, 1'b1, 1'b0, f_fetch(1'b1));
    cyc("swr_decode", I_SW, 1'b0, 1'b1, 1'b0, f_dec());
    cyc("swr_memadr", I_SW, 1'b0, 1'b1, 1'b0,
        ex(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("swr_memwrite", I_SW, 1'b0, 1'b0, 1'b0,
        ex(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("swr_memwrite_rst", I_SW, 1'b0, 1'b0, 1'b1,
        ex(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A_ADD, 1'b0, 1'b0, 1'b0));
    cyc("swr_after_rst", I_ADD, 1'b0, 1'b1, 1'b0, f_fetch(1'b1));

    n_assert++;
    assert (sb_q.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
